lbdr_input_fifo: RTL and testbench

- Per-input-port flit buffer sitting directly upstream of the router's LBDR stage.
- Stores incoming flits from the neighbouring router or local NI and presents the head flit first-word-fall-through.
- Drives LBDR's `empty`, `flit_id` and `dst_addr` from the head flit.
- Returns credits upstream and checks packet framing on the write side.

---
 rtl/noc_pkg.sv | 32 +++
 rtl/lbdr_frame_checker.sv | 60 ++++++
 rtl/lbdr_input_fifo.sv | 122 ++++++++++++
 tb/tb_lbdr_input_fifo.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : noc_pkg
//  Purpose  : Shared NoC definitions. Flit type encodings, flit field
//             positions, the flit_id type and the write-side framing states.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package noc_pkg;

    typedef logic [2:0] flit_id_t;

    // One-hot flit type encodings carried in the flit_id field
    localparam flit_id_t HEADER = 3'b001;
    localparam flit_id_t BODY   = 3'b010;
    localparam flit_id_t TAIL   = 3'b100;

    // Flit field positions (header flits carry dst/src, all carry flit_id)
    localparam int FLIT_ID_MSB = 31;
    localparam int FLIT_ID_LSB = 29;
    localparam int DST_MSB     = 28;
    localparam int DST_LSB     = 25;
    localparam int SRC_MSB     = 24;
    localparam int SRC_LSB     = 21;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } frame_state_t;

endpackage : noc_pkg
`default_nettype wire

// File: rtl/lbdr_frame_checker.sv
`default_nettype none
// ============================================================================
//  Module   : lbdr_frame_checker
//  Purpose  : Write-side packet framing monitor. Tracks whether the stream
//             is between packets or inside one and raises a sticky error on
//             any flit type that is illegal in the current state.
//  Ports    : clk        - router clock
//             rst        - synchronous active-high reset
//             wr_i       - a flit is being accepted into the FIFO
//             flit_id_i  - flit_id field of the accepted flit
//             proto_err_o- sticky framing error (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module lbdr_frame_checker
    import noc_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     wr_i,
    input  flit_id_t flit_id_i,
    output logic     proto_err_o
);

    frame_state_t state_q;
    logic         proto_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            proto_err_q <= 1'b0;
        end else if (wr_i) begin
            case (state_q)
                IDLE: begin
                    // Only a header may open a packet
                    if (flit_id_i == HEADER) begin
                        state_q <= IN_PKT;
                    end else begin
                        proto_err_q <= 1'b1;
                    end
                end
                IN_PKT: begin
                    if (flit_id_i == TAIL) begin
                        state_q <= IDLE;
                    end else if (flit_id_i != BODY) begin
                        // A stray header is treated as the start of a new
                        // packet, so the state stays IN_PKT.
                        proto_err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign proto_err_o = proto_err_q;

endmodule : lbdr_frame_checker
`default_nettype wire

// File: rtl/lbdr_input_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : lbdr_input_fifo
//  Purpose  : Per-input-port first-word-fall-through flit buffer feeding the
//             LBDR stage. Presents the head flit and its flit_id/dst_addr
//             fields, returns one credit per flit removed and flags write
//             overflow and framing errors.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             valid_in, rx_flit - incoming flit and its valid
//             read_en_{N,E,W,S,L}- output-port grants for the head flit
//             tx_flit           - head flit (combinational from storage)
//             empty, full       - occupancy flags
//             flit_id, dst_addr - head flit fields for LBDR
//             credit_out        - one-cycle pulse per flit removed
//             overflow_err      - sticky: write dropped while full
//             proto_err         - sticky: framing violation
//  Revision : 1.0 - initial release
// ============================================================================
module lbdr_input_fifo
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] rx_flit,
    input  logic                  read_en_N,
    input  logic                  read_en_E,
    input  logic                  read_en_W,
    input  logic                  read_en_S,
    input  logic                  read_en_L,
    output logic [DATA_WIDTH-1:0] tx_flit,
    output logic                  empty,
    output logic                  full,
    output logic [2:0]            flit_id,
    output logic [3:0]            dst_addr,
    output logic                  credit_out,
    output logic                  overflow_err,
    output logic                  proto_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] C_DEPTH = (PTR_W+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q,  count_d;
    logic                  credit_q;
    logic                  overflow_q;

    logic w_rd;
    logic w_wr;

    assign empty = (count_q == '0);
    assign full  = (count_q == C_DEPTH);

    // Any grant counts as a single read; grants while empty are ignored
    assign w_rd = (read_en_N | read_en_E | read_en_W | read_en_S | read_en_L) & ~empty;
    // A read in the same cycle frees the slot the write reuses
    assign w_wr = valid_in & (~full | w_rd);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_wr, w_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            credit_q <= w_rd;
            if (valid_in && full && !w_rd) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: contents are only observed once count > 0
    always_ff @(posedge clk) begin
        if (!rst && w_wr) begin
            mem_q[wr_ptr_q] <= rx_flit;
        end
    end

    assign tx_flit      = mem_q[rd_ptr_q];
    assign flit_id      = tx_flit[FLIT_ID_MSB:FLIT_ID_LSB];
    assign dst_addr     = tx_flit[DST_MSB:DST_LSB];
    assign credit_out   = credit_q;
    assign overflow_err = overflow_q;

    lbdr_frame_checker u_frame_checker (
        .clk         (clk),
        .rst         (rst),
        .wr_i        (w_wr),
        .flit_id_i   (rx_flit[FLIT_ID_MSB:FLIT_ID_LSB]),
        .proto_err_o (proto_err)
    );

endmodule : lbdr_input_fifo
`default_nettype wire

// File: tb/tb_lbdr_input_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lbdr_input_fifo
//  Purpose  : Directed self-checking bench for lbdr_input_fifo (DEPTH = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lbdr_input_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] rx_flit;
    logic        read_en_N, read_en_E, read_en_W, read_en_S, read_en_L;
    logic [31:0] tx_flit;
    logic        empty, full;
    logic [2:0]  flit_id;
    logic [3:0]  dst_addr;
    logic        credit_out, overflow_err, proto_err;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Grant masks {N,E,W,S,L}
    localparam logic [4:0] RN = 5'b10000;
    localparam logic [4:0] RE = 5'b01000;
    localparam logic [4:0] RL = 5'b00001;

    // Hand-built flits
    localparam logic [31:0] FH  = {3'b001, 4'hA, 4'h3, 21'h00001};
    localparam logic [31:0] FB1 = {3'b010, 29'h0000_0B1};
    localparam logic [31:0] FB2 = {3'b010, 29'h0000_0B2};
    localparam logic [31:0] FT  = {3'b100, 29'h0000_0CC};
    localparam logic [31:0] FH2 = {3'b001, 4'h5, 4'h1, 21'h00002};
    localparam logic [31:0] FBX = {3'b010, 29'h0DEAD00};

    logic [31:0] seq [10];

    lbdr_input_fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .rx_flit      (rx_flit),
        .read_en_N    (read_en_N),
        .read_en_E    (read_en_E),
        .read_en_W    (read_en_W),
        .read_en_S    (read_en_S),
        .read_en_L    (read_en_L),
        .tx_flit      (tx_flit),
        .empty        (empty),
        .full         (full),
        .flit_id      (flit_id),
        .dst_addr     (dst_addr),
        .credit_out   (credit_out),
        .overflow_err (overflow_err),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, step past the edge, then return inputs idle
    task automatic cyc(input logic v, input logic [31:0] f, input logic [4:0] re);
        valid_in  = v;
        rx_flit   = f;
        {read_en_N, read_en_E, read_en_W, read_en_S, read_en_L} = re;
        @(posedge clk);
        #1;
        valid_in  = 1'b0;
        rx_flit   = '0;
        {read_en_N, read_en_E, read_en_W, read_en_S, read_en_L} = 5'b0;
    endtask

    task automatic do_reset(input int n, input logic [4:0] re);
        rst = 1'b1;
        {read_en_N, read_en_E, read_en_W, read_en_S, read_en_L} = re;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        {read_en_N, read_en_E, read_en_W, read_en_S, read_en_L} = 5'b0;
    endtask

    initial begin
        valid_in = 1'b0;
        rx_flit  = '0;
        {read_en_N, read_en_E, read_en_W, read_en_S, read_en_L} = 5'b0;

        // ---------------- reset then idle
        do_reset(2, 5'b0);
        chk("rst_empty",    32'(empty),        32'd1);
        chk("rst_full",     32'(full),         32'd0);
        chk("rst_credit",   32'(credit_out),   32'd0);
        chk("rst_ovf",      32'(overflow_err), 32'd0);
        chk("rst_proto",    32'(proto_err),    32'd0);
        cyc(1'b0, '0, 5'b0);
        chk("idle_empty",   32'(empty),        32'd1);

        // ---------------- fill to DEPTH
        cyc(1'b1, FH, 5'b0);
        chk("fill1_empty",  32'(empty),        32'd0);
        chk("fill1_id",     32'(flit_id),      32'd1);
        chk("fill1_dst",    32'(dst_addr),     32'hA);
        chk("fill1_tx",     tx_flit,           FH);
        cyc(1'b1, FB1, 5'b0);
        cyc(1'b1, FB2, 5'b0);
        chk("fill3_full",   32'(full),         32'd0);
        cyc(1'b1, FT, 5'b0);
        chk("fill4_full",   32'(full),         32'd1);
        chk("fill4_head",   tx_flit,           FH);
        chk("fill4_proto",  32'(proto_err),    32'd0);

        // ---------------- drain via East
        cyc(1'b0, '0, RE);
        chk("drain1_tx",    tx_flit,           FB1);
        chk("drain1_cr",    32'(credit_out),   32'd1);
        chk("drain1_full",  32'(full),         32'd0);
        cyc(1'b0, '0, RE);
        chk("drain2_tx",    tx_flit,           FB2);
        chk("drain2_cr",    32'(credit_out),   32'd1);
        cyc(1'b0, '0, RE);
        chk("drain3_tx",    tx_flit,           FT);
        chk("drain3_id",    32'(flit_id),      32'd4);
        chk("drain3_cr",    32'(credit_out),   32'd1);
        cyc(1'b0, '0, RE);
        chk("drain4_empty", 32'(empty),        32'd1);
        chk("drain4_cr",    32'(credit_out),   32'd1);
        cyc(1'b0, '0, RE);
        chk("rd_empty_cr",  32'(credit_out),   32'd0);
        chk("rd_empty_emp", 32'(empty),        32'd1);

        // ---------------- full with same-cycle read+write, then overflow
        cyc(1'b1, FH, 5'b0);
        cyc(1'b1, FB1, 5'b0);
        cyc(1'b1, FB2, 5'b0);
        cyc(1'b1, FT, 5'b0);
        chk("rw_pre_full",  32'(full),         32'd1);
        cyc(1'b1, FH2, RN);
        chk("rw_full",      32'(full),         32'd1);
        chk("rw_ovf",       32'(overflow_err), 32'd0);
        chk("rw_cr",        32'(credit_out),   32'd1);
        chk("rw_tx",        tx_flit,           FB1);
        cyc(1'b1, FBX, 5'b0);
        chk("ovf_set",      32'(overflow_err), 32'd1);
        chk("ovf_cr",       32'(credit_out),   32'd0);
        chk("ovf_full",     32'(full),         32'd1);
        chk("ovf_proto",    32'(proto_err),    32'd0);
        cyc(1'b0, '0, RN);
        chk("rwd1_tx",      tx_flit,           FB2);
        cyc(1'b0, '0, RN);
        chk("rwd2_tx",      tx_flit,           FT);
        cyc(1'b0, '0, RN);
        chk("rwd3_tx",      tx_flit,           FH2);
        chk("rwd3_dst",     32'(dst_addr),     32'h5);
        cyc(1'b0, '0, RN);
        chk("rwd4_empty",   32'(empty),        32'd1);
        chk("ovf_sticky",   32'(overflow_err), 32'd1);

        // ---------------- framing
        do_reset(1, 5'b0);
        chk("fr_rst_ovf",   32'(overflow_err), 32'd0);
        cyc(1'b1, FB1, 5'b0);
        chk("fr_body_err",  32'(proto_err),    32'd1);
        chk("fr_body_emp",  32'(empty),        32'd0);
        chk("fr_body_tx",   tx_flit,           FB1);
        do_reset(1, 5'b0);
        chk("fr_rst_proto", 32'(proto_err),    32'd0);
        cyc(1'b1, FH, 5'b0);
        chk("fr_h_ok",      32'(proto_err),    32'd0);
        cyc(1'b1, FH2, 5'b0);
        chk("fr_hh_err",    32'(proto_err),    32'd1);
        do_reset(1, 5'b0);
        cyc(1'b1, FH, 5'b0);
        cyc(1'b1, FT, 5'b0);
        chk("fr_ht_ok",     32'(proto_err),    32'd0);

        // ---------------- wrap-around, two flits in flight
        do_reset(1, 5'b0);
        seq[0] = FH;
        for (int k = 1; k < 9; k++) seq[k] = {3'b010, 29'(k * 32'h111)};
        seq[9] = FT;
        cyc(1'b1, seq[0], 5'b0);
        cyc(1'b1, seq[1], 5'b0);
        for (int k = 2; k < 10; k++) begin
            cyc(1'b1, seq[k], RL);
            chk($sformatf("wrap%0d_tx", k), tx_flit, seq[k-1]);
            chk($sformatf("wrap%0d_cr", k), 32'(credit_out), 32'd1);
        end
        cyc(1'b0, '0, RL);
        chk("wrap_last_tx", tx_flit,           seq[9]);
        cyc(1'b0, '0, RL);
        chk("wrap_empty",   32'(empty),        32'd1);
        chk("wrap_proto",   32'(proto_err),    32'd0);

        // ---------------- reset mid-packet with 2 flits stored
        cyc(1'b1, FH, 5'b0);
        cyc(1'b1, FB1, 5'b0);
        chk("mid_pre_emp",  32'(empty),        32'd0);
        do_reset(1, RL);
        chk("mid_empty",    32'(empty),        32'd1);
        chk("mid_full",     32'(full),         32'd0);
        chk("mid_cr",       32'(credit_out),   32'd0);
        cyc(1'b0, '0, 5'b0);
        chk("mid_cr2",      32'(credit_out),   32'd0);
        cyc(1'b1, FH2, 5'b0);
        chk("mid_h_proto",  32'(proto_err),    32'd0);
        chk("mid_h_tx",     tx_flit,           FH2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_lbdr_input_fifo
`default_nettype wire
